// File: rtl/gate_scan_ctrl.sv
// gate_scan_ctrl: exhaustive truth-table scan of an 8-function gate-select mux.
// Walks all 32 {select, sw1, sw0} combinations. For each one it drives the
// operands, waits SETTLE cycles, then samples mux_out and compares it with the
// golden table. It reports the captured table, a mismatch count and a pass flag.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   S_IDLE   | waiting for start; drives and last results held
//   S_DRIVE  | register select/sw1/sw0 from idx
//   S_SETTLE | hold drives for SETTLE cycles (down-counter to zero)
//   S_SAMPLE | capture mux_out into result[idx], count mismatches
//   S_DONE   | one-cycle done pulse, pass reflects the whole scan
module gate_scan_ctrl #(
  parameter int unsigned SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        mux_out,
  output logic        sw0,
  output logic        sw1,
  output logic [2:0]  select,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [31:0] result,
  output logic [5:0]  err_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  // Nibble per select value: NOT sw0, BUF sw0, XNOR, XOR, OR, NOR, AND, NAND.
  localparam logic [31:0] GOLDEN = 32'h781E69A5;

  // The settle counter counts SETTLE-1 down to 0, giving SETTLE cycles in
  // S_SETTLE. With SETTLE=0 the state is skipped and the load value is unused.
  localparam logic [3:0] SETTLE_LOAD = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);

  state_t      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        sw0_q, sw0_d;
  logic        sw1_q, sw1_d;
  logic [2:0]  select_q, select_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [31:0] result_q, result_d;
  logic [5:0]  err_q, err_d;

  // Next-state and next-output computation for the scan sequencer.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    sw0_d    = sw0_q;
    sw1_d    = sw1_q;
    select_d = select_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    result_d = result_q;
    err_d    = err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          result_d = '0;
          err_d    = '0;
          pass_d   = 1'b0;
          idx_d    = '0;
          state_d  = S_DRIVE;
        end
      end

      S_DRIVE: begin
        select_d = idx_q[4:2];
        sw1_d    = idx_q[1];
        sw0_d    = idx_q[0];
        if (SETTLE == 0) begin
          state_d = S_SAMPLE;
        end else begin
          cnt_d   = SETTLE_LOAD;
          state_d = S_SETTLE;
        end
      end

      S_SETTLE: begin
        if (cnt_q == 4'd0) begin
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_SAMPLE: begin
        result_d[idx_q] = mux_out;
        if (mux_out != GOLDEN[idx_q]) begin
          err_d = err_q + 6'd1;
        end
        if (idx_q == 5'd31) begin
          // pass must include the mismatch from this final sample.
          state_d = S_DONE;
          done_d  = 1'b1;
          pass_d  = (err_d == 6'd0);
        end else begin
          idx_d   = idx_q + 5'd1;
          state_d = S_DRIVE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort leaves result/err_count as partial values but never reports a pass.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      pass_d  = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      sw0_q    <= 1'b0;
      sw1_q    <= 1'b0;
      select_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      result_q <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      sw0_q    <= sw0_d;
      sw1_q    <= sw1_d;
      select_q <= select_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign sw0       = sw0_q;
  assign sw1       = sw1_q;
  assign select    = select_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign result    = result_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_gate_scan_ctrl.sv
// Testbench for gate_scan_ctrl: two instances (SETTLE=2 and SETTLE=0), each
// driving a behavioural gate mux with an injectable output-flip fault mask.
module tb_gate_scan_ctrl;

  logic        clk;
  logic        rst;
  logic        start_v  [2];
  logic        abort_v  [2];
  logic        mux_v    [2];
  logic        sw0_v    [2];
  logic        sw1_v    [2];
  logic [2:0]  sel_v    [2];
  logic        busy_v   [2];
  logic        done_v   [2];
  logic        pass_v   [2];
  logic [31:0] res_v    [2];
  logic [5:0]  err_v    [2];
  logic [31:0] mask_v   [2];

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] ref_tab;

  typedef struct {
    int          k;
    logic [31:0] mask;
    logic [31:0] exp_res;
    int          exp_err;
    bit          exp_pass;
    int          exp_cyc;
  } rec_t;

  rec_t vec [8];

  // Ideal gate behaviour selected by sel, operands a=sw1, b=sw0.
  function automatic logic gate(input logic [2:0] sel, input logic a, input logic b);
    case (sel)
      3'd0:    return !b;
      3'd1:    return b;
      3'd2:    return !(a ^ b);
      3'd3:    return a ^ b;
      3'd4:    return a | b;
      3'd5:    return !(a | b);
      3'd6:    return a & b;
      default: return !(a & b);
    endcase
  endfunction

  assign mux_v[0] = gate(sel_v[0], sw1_v[0], sw0_v[0]) ^ mask_v[0][{sel_v[0], sw1_v[0], sw0_v[0]}];
  assign mux_v[1] = gate(sel_v[1], sw1_v[1], sw0_v[1]) ^ mask_v[1][{sel_v[1], sw1_v[1], sw0_v[1]}];

  gate_scan_ctrl #(.SETTLE(2)) u_s2 (
    .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort_v[0]), .mux_out(mux_v[0]),
    .sw0(sw0_v[0]), .sw1(sw1_v[0]), .select(sel_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .pass(pass_v[0]), .result(res_v[0]), .err_count(err_v[0])
  );

  gate_scan_ctrl #(.SETTLE(0)) u_s0 (
    .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort_v[1]), .mux_out(mux_v[1]),
    .sw0(sw0_v[1]), .sw1(sw1_v[1]), .select(sel_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .pass(pass_v[1]), .result(res_v[1]), .err_count(err_v[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_state(input int k, input string tag);
    check({tag, " busy"},   32'(busy_v[k]), 32'd0);
    check({tag, " done"},   32'(done_v[k]), 32'd0);
    check({tag, " pass"},   32'(pass_v[k]), 32'd0);
    check({tag, " result"}, res_v[k], 32'd0);
    check({tag, " err"},    32'(err_v[k]), 32'd0);
    check({tag, " drives"}, 32'({sel_v[k], sw1_v[k], sw0_v[k]}), 32'd0);
  endtask

  // Pulse start, then follow the scan to its done pulse and check the outcome.
  task automatic run_scan(input int k, input logic [31:0] exp_res, input int exp_err,
                          input bit exp_pass, input int exp_cyc, input string tag);
    int  n;
    bit  got;
    @(negedge clk);
    start_v[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[k] = 1'b0;
    check({tag, " busy_cycle1"}, 32'(busy_v[k]), 32'd1);
    n   = 1;
    got = 1'b0;
    while (n <= 2000 && !got) begin
      if (done_v[k]) got = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    check({tag, " done_cycle"}, got ? 32'(n) : 32'hFFFF_FFFF, 32'(exp_cyc));
    check({tag, " result"}, res_v[k], exp_res);
    check({tag, " err_count"}, 32'(err_v[k]), 32'(exp_err));
    check({tag, " pass"}, 32'(pass_v[k]), 32'(exp_pass));
    @(negedge clk);
    check({tag, " done_one_cycle"}, 32'(done_v[k]), 32'd0);
    check({tag, " busy_after"}, 32'(busy_v[k]), 32'd0);
  endtask

  initial begin
    int          dones;
    int          busy_low;
    logic [31:0] pm;

    // Reference truth table computed from the gate behaviour, not the constant.
    for (int i = 0; i < 32; i++) begin
      logic [4:0] ii;
      ii = i[4:0];
      ref_tab[i] = gate(ii[4:2], ii[1], ii[0]);
    end

    vec[0] = '{0, 32'h0000_0000, 32'h781E_69A5, 0, 1'b1, 129};
    vec[1] = '{0, 32'h0000_6000, 32'h781E_09A5, 2, 1'b0, 129};
    vec[2] = '{0, 32'hFFFF_FFFF, 32'h0, 0, 1'b0, 129};
    vec[3] = '{0, $urandom, 32'h0, 0, 1'b0, 129};
    vec[4] = '{0, $urandom & $urandom & $urandom, 32'h0, 0, 1'b0, 129};
    vec[5] = '{0, 32'h8000_0000, 32'h0, 0, 1'b0, 129};
    vec[6] = '{1, 32'h0000_0000, 32'h781E_69A5, 0, 1'b1, 65};
    vec[7] = '{1, $urandom, 32'h0, 0, 1'b0, 65};
    for (int i = 2; i < 8; i++) begin
      if (i != 6) begin
        vec[i].exp_res  = ref_tab ^ vec[i].mask;
        vec[i].exp_err  = $countones(vec[i].mask);
        vec[i].exp_pass = (vec[i].mask == 32'h0);
      end
    end

    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      start_v[k] = 1'b0;
      abort_v[k] = 1'b0;
      mask_v[k]  = 32'h0;
    end
    repeat (3) @(negedge clk);
    check_reset_state(0, "reset_s2");
    check_reset_state(1, "reset_s0");
    rst = 1'b0;

    // Table-driven full scans.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      mask_v[vec[i].k] = vec[i].mask;
      run_scan(vec[i].k, vec[i].exp_res, vec[i].exp_err, vec[i].exp_pass,
               vec[i].exp_cyc, $sformatf("vec%0d", i));
    end

    // Start and abort together in IDLE: start wins. Then abort at cycle 50.
    @(negedge clk);
    mask_v[0]  = 32'h0000_0104;
    start_v[0] = 1'b1;
    abort_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    abort_v[0] = 1'b0;
    check("start_over_abort busy", 32'(busy_v[0]), 32'd1);
    dones = 0;
    for (int n = 2; n <= 50; n++) begin
      @(negedge clk);
      if (done_v[0]) dones++;
    end
    abort_v[0] = 1'b1;
    @(negedge clk);
    abort_v[0] = 1'b0;
    if (done_v[0]) dones++;
    pm = (ref_tab ^ mask_v[0]) & 32'h0000_0FFF;
    check("abort busy", 32'(busy_v[0]), 32'd0);
    check("abort no_done", 32'(dones), 32'd0);
    check("abort pass", 32'(pass_v[0]), 32'd0);
    check("abort partial_result", res_v[0], pm);
    check("abort partial_err", 32'(err_v[0]), 32'($countones(mask_v[0] & 32'h0000_0FFF)));
    mask_v[0] = 32'h0;
    run_scan(0, 32'h781E_69A5, 0, 1'b1, 129, "after_abort");

    // Reset at cycle 70 of a scan.
    @(negedge clk);
    mask_v[0]  = 32'h0000_0010;
    start_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (69) @(negedge clk);
    check("pre_rst partial_err", 32'(err_v[0]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state(0, "midscan_rst");
    mask_v[0] = 32'h0;
    run_scan(0, 32'h781E_69A5, 0, 1'b1, 129, "after_rst");

    // Start held high for 300 cycles.
    @(negedge clk);
    start_v[0] = 1'b1;
    @(posedge clk);
    dones    = 0;
    busy_low = 0;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      if (done_v[0]) begin
        dones++;
        if (dones == 1) check("held first_done_cycle", 32'(n), 32'd129);
        if (dones == 2) check("held second_done_cycle", 32'(n), 32'd259);
      end
      if (n <= 259 && !busy_v[0]) busy_low++;
    end
    start_v[0] = 1'b0;
    check("held done_count", 32'(dones), 32'd2);
    check("held busy_low_cycles", 32'(busy_low), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("held cleanup busy", 32'(busy_v[0]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
